// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for the digit-serial adder/subtractor.
// The requester drives the master side; the serial_addsub block is the slave.
interface serial_addsub_if #(
  parameter int unsigned WIDTH = 16
);

  logic             start;
  logic             ready;
  logic             sub;
  logic [WIDTH-1:0] a_input;
  logic [WIDTH-1:0] b_input;
  logic             c_input;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             overflow;
  logic             done;
  logic             busy;

  modport master (
    output start, sub, a_input, b_input, c_input,
    input  ready, sum, carryout, overflow, done, busy
  );

  modport slave (
    input  start, sub, a_input, b_input, c_input,
    output ready, sum, carryout, overflow, done, busy
  );

endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: CHUNK bits per clock, LSB chunk first, with a
// start/ready/done handshake, subtract mode and signed-overflow reporting.
module serial_addsub #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic           clk,
  input  logic           rst,
  serial_addsub_if.slave bus
);

  localparam int unsigned N     = WIDTH / CHUNK;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_n;

  // Working state of the operation in flight
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;

  // Visible results and handshake flags
  logic [WIDTH-1:0] sum_q;
  logic             carryout_q;
  logic             overflow_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  logic             ready_n;
  logic             busy_n;
  logic             done_n;

  logic             accept;
  logic             last_chunk;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] res_n;
  logic             top_a;
  logic             top_b;
  logic             top_s;

  assign accept     = (state_q == S_IDLE) && bus.start;
  assign last_chunk = (cnt_q == CNT_W'(N - 1));

  // One chunk of the ripple: lowest unprocessed bits plus the running carry
  assign chunk_sum = {1'b0, a_q[CHUNK-1:0]}
                   + {1'b0, b_q[CHUNK-1:0]}
                   + (CHUNK + 1)'(carry_q);

  // Chunk sum enters the result register from the MSB side
  assign res_n = (res_q >> CHUNK)
               | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

  // Sign bits seen during the last chunk decide signed overflow
  assign top_a = a_q[CHUNK-1];
  assign top_b = b_q[CHUNK-1];
  assign top_s = chunk_sum[CHUNK-1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (last_chunk) begin
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Handshake flags follow the state being entered so they register cleanly
  always_comb begin
    ready_n = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    case (state_n)
      S_IDLE:  ready_n = 1'b1;
      S_RUN:   busy_n  = 1'b1;
      S_DONE: begin
        busy_n = 1'b1;
        done_n = 1'b1;
      end
      default: ready_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= ready_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Operand capture and chunk-by-chunk processing
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= bus.a_input;
      b_q     <= bus.sub ? ~bus.b_input : bus.b_input;
      carry_q <= bus.sub ? ~bus.c_input : bus.c_input;
      res_q   <= '0;
      cnt_q   <= '0;
    end else if (state_q == S_RUN) begin
      a_q     <= a_q >> CHUNK;
      b_q     <= b_q >> CHUNK;
      res_q   <= res_n;
      carry_q <= chunk_sum[CHUNK];
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Results only change at completion, so partial sums never leak out
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q      <= '0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if ((state_q == S_RUN) && last_chunk) begin
      sum_q      <= res_n;
      carryout_q <= chunk_sum[CHUNK];
      overflow_q <= (top_a == top_b) && (top_s != top_a);
    end
  end

  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.carryout = carryout_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: three configurations (16/4, 8/8, 8/1),
// directed vectors with hand-computed results checked on each done pulse.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] sum;
    logic        co;
    logic        ov;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t e0, e1, e2;

  serial_addsub_if #(.WIDTH(16)) i16 ();
  serial_addsub_if #(.WIDTH(8))  i88 ();
  serial_addsub_if #(.WIDTH(8))  i81 ();

  serial_addsub #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .rst(rst), .bus(i16));
  serial_addsub #(.WIDTH(8),  .CHUNK(8)) u88 (.clk(clk), .rst(rst), .bus(i88));
  serial_addsub #(.WIDTH(8),  .CHUNK(1)) u81 (.clk(clk), .rst(rst), .bus(i81));

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic rdy(input int d);
    case (d)
      0:       return i16.ready;
      1:       return i88.ready;
      default: return i81.ready;
    endcase
  endfunction

  function automatic int nof(input int d);
    case (d)
      0:       return 4;
      1:       return 1;
      default: return 8;
    endcase
  endfunction

  task automatic drive(input int d, input logic st, input logic s,
                       input logic [15:0] a, input logic [15:0] b, input logic c);
    case (d)
      0: begin
        i16.start = st; i16.sub = s; i16.a_input = a; i16.b_input = b; i16.c_input = c;
      end
      1: begin
        i88.start = st; i88.sub = s; i88.a_input = a[7:0]; i88.b_input = b[7:0]; i88.c_input = c;
      end
      default: begin
        i81.start = st; i81.sub = s; i81.a_input = a[7:0]; i81.b_input = b[7:0]; i81.c_input = c;
      end
    endcase
  endtask

  // Called at a falling edge; returns at the falling edge right after the accept edge
  task automatic issue(input int d, input logic s, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic [15:0] es, input logic eco, input logic eov,
                       input bit push);
    int t;
    exp_t e;
    t = 0;
    while (rdy(d) !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout dut%0d: ready stayed low, want 1", d);
    end
    drive(d, 1'b1, s, a, b, c);
    if (push) begin
      e = '{sum: es, co: eco, ov: eov, due: cyc + 1 + nof(d)};
      case (d)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
    @(negedge clk);
    drive(d, 1'b0, s, a, b, c);
  endtask

  // Monitors: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (i16.done === 1'b1) begin
      if (q0.size() == 0) begin
        tests++; fails++;
        $display("FAIL done16: unexpected done at cycle %0d, want none", cyc);
      end else begin
        e0 = q0.pop_front();
        cmp("sum16", 32'(i16.sum), 32'(e0.sum));
        cmp("carry16", 32'(i16.carryout), 32'(e0.co));
        cmp("ovf16", 32'(i16.overflow), 32'(e0.ov));
        cmp("latency16", 32'(cyc), 32'(e0.due));
      end
    end
  end

  always @(negedge clk) begin
    if (i88.done === 1'b1) begin
      if (q1.size() == 0) begin
        tests++; fails++;
        $display("FAIL done88: unexpected done at cycle %0d, want none", cyc);
      end else begin
        e1 = q1.pop_front();
        cmp("sum88", 32'(i88.sum), 32'(e1.sum));
        cmp("carry88", 32'(i88.carryout), 32'(e1.co));
        cmp("ovf88", 32'(i88.overflow), 32'(e1.ov));
        cmp("latency88", 32'(cyc), 32'(e1.due));
      end
    end
  end

  always @(negedge clk) begin
    if (i81.done === 1'b1) begin
      if (q2.size() == 0) begin
        tests++; fails++;
        $display("FAIL done81: unexpected done at cycle %0d, want none", cyc);
      end else begin
        e2 = q2.pop_front();
        cmp("sum81", 32'(i81.sum), 32'(e2.sum));
        cmp("carry81", 32'(i81.carryout), 32'(e2.co));
        cmp("ovf81", 32'(i81.overflow), 32'(e2.ov));
        cmp("latency81", 32'(cyc), 32'(e2.due));
      end
    end
  end

  initial begin
    int t;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(2, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    cmp("rst_ready16", 32'(i16.ready), 32'd1);
    cmp("rst_busy16", 32'(i16.busy), 32'd0);
    cmp("rst_done16", 32'(i16.done), 32'd0);
    cmp("rst_sum16", 32'(i16.sum), 32'd0);
    cmp("rst_carry16", 32'(i16.carryout), 32'd0);
    cmp("rst_ovf16", 32'(i16.overflow), 32'd0);
    cmp("rst_ready88", 32'(i88.ready), 32'd1);
    cmp("rst_ready81", 32'(i81.ready), 32'd1);

    // Basic add with handshake timing: ready low for 5 cycles
    issue(0, 1'b0, 16'h0007, 16'h0002, 1'b0, 16'h0009, 1'b0, 1'b0, 1'b1);
    cmp("ready_low0", 32'(i16.ready), 32'd0);
    cmp("busy_high0", 32'(i16.busy), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      cmp("ready_low", 32'(i16.ready), 32'd0);
    end
    @(negedge clk);
    cmp("ready_back", 32'(i16.ready), 32'd1);
    cmp("busy_back", 32'(i16.busy), 32'd0);

    issue(0, 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    issue(0, 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    issue(0, 1'b0, 16'h0004, 16'h0003, 1'b1, 16'h0008, 1'b0, 1'b0, 1'b1);
    issue(0, 1'b1, 16'h0004, 16'h0003, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b1);
    issue(0, 1'b1, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);
    issue(0, 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    issue(0, 1'b1, 16'h0005, 16'h0002, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1);

    // Starts during RUN and during DONE must be ignored
    issue(0, 1'b0, 16'h1000, 16'h0234, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 16'h8000, 16'h0001, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    cmp("ign_ready", 32'(i16.ready), 32'd1);
    @(negedge clk);
    cmp("ign_idle_ready", 32'(i16.ready), 32'd1);
    cmp("ign_idle_busy", 32'(i16.busy), 32'd0);
    cmp("ign_sum_held", 32'(i16.sum), 32'h1234);

    // Reset on the 2nd RUN edge aborts without a done pulse
    issue(0, 1'b0, 16'h1111, 16'h2222, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmp("mid_rst_ready", 32'(i16.ready), 32'd1);
    cmp("mid_rst_busy", 32'(i16.busy), 32'd0);
    cmp("mid_rst_done", 32'(i16.done), 32'd0);
    cmp("mid_rst_sum", 32'(i16.sum), 32'd0);
    cmp("mid_rst_carry", 32'(i16.carryout), 32'd0);
    cmp("mid_rst_ovf", 32'(i16.overflow), 32'd0);
    repeat (6) @(negedge clk);
    issue(0, 1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b1);

    // Full-width chunk and single-bit chunk configurations
    issue(1, 1'b0, 16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    issue(1, 1'b1, 16'h0005, 16'h0007, 1'b0, 16'h00FE, 1'b0, 1'b0, 1'b1);
    issue(2, 1'b0, 16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b1);
    issue(2, 1'b0, 16'h007F, 16'h007F, 1'b1, 16'h00FF, 1'b0, 1'b1, 1'b1);

    t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    cmp("pending_results", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
